// File: rtl/psum_deskew_collector.sv
// Re-aligns the column-skewed partial-sum stream of a systolic array into whole
// rows and buffers them in a small FIFO drained by a valid/ready handshake.
module psum_deskew_collector #(
  parameter int PSUM_WIDTH  = 32,
  parameter int ARRAY_WIDTH = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ARRAY_WIDTH*PSUM_WIDTH-1:0] psum_in,
  input  logic                              psum_valid,
  output logic [ARRAY_WIDTH*PSUM_WIDTH-1:0] row_data,
  output logic                              row_valid,
  input  logic                              row_ready,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output logic                              overflow,
  output logic [15:0]                       rows_out
);

  localparam int ROW_W = ARRAY_WIDTH * PSUM_WIDTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  logic [ROW_W-1:0]       aligned_row;
  logic [ARRAY_WIDTH-2:0] vld_line;
  logic                   aligned_valid;

  // Deskew stage: psum_valid delayed W-1 cycles marks the cycle the full row lines up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_line <= '0;
    end else begin
      vld_line[0] <= psum_valid;
      for (int i = 1; i < ARRAY_WIDTH - 1; i++) begin
        vld_line[i] <= vld_line[i-1];
      end
    end
  end

  assign aligned_valid = vld_line[ARRAY_WIDTH-2];

  genvar c;
  generate
    for (c = 0; c < ARRAY_WIDTH - 1; c++) begin : g_skew
      localparam int DEPTH = ARRAY_WIDTH - 1 - c;
      logic [PSUM_WIDTH-1:0] line [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            line[i] <= '0;
          end
        end else begin
          line[0] <= psum_in[c*PSUM_WIDTH +: PSUM_WIDTH];
          for (int i = 1; i < DEPTH; i++) begin
            line[i] <= line[i-1];
          end
        end
      end

      assign aligned_row[c*PSUM_WIDTH +: PSUM_WIDTH] = line[DEPTH-1];
    end
  endgenerate

  // The last column is already the latest to arrive, so it needs no delay
  assign aligned_row[(ARRAY_WIDTH-1)*PSUM_WIDTH +: PSUM_WIDTH] =
    psum_in[(ARRAY_WIDTH-1)*PSUM_WIDTH +: PSUM_WIDTH];

  logic [ROW_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             push;
  logic             pop;
  logic             drop;

  assign full = (count == CW'(FIFO_DEPTH));
  assign pop  = row_valid & row_ready;
  // A full FIFO still accepts a row when the head leaves in the same cycle
  assign push = aligned_valid & (~full | pop);
  assign drop = aligned_valid & full & ~pop;

  // FIFO stage: storage holds data only, control carries the reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= aligned_row;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rows_out <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        rows_out <= rows_out + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign row_valid  = (count != '0);
  assign row_data   = row_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

endmodule

// File: doc/psum_deskew_collector.md
# psum_deskew_collector

Output-side companion of `systolic_array_with_skew`. Accepts the column-skewed partial-sum stream from the array's `psum_out` (column c lags column 0 by c cycles), re-aligns each result row so all columns present together, and buffers aligned rows in a small FIFO drained by a valid/ready handshake. The array cannot stall, so the collector never back-pressures it. Overflow is flagged instead.

## Interface

Parameters:
- `PSUM_WIDTH`, 32, width of one partial sum.
- `ARRAY_WIDTH`, 4, number of array columns (W), ≥2.
- `FIFO_DEPTH`, 4, aligned-row buffer depth, power of two, ≥2.

Ports:
- `clk`, input, 1, sole clock, rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `psum_in`, input, ARRAY_WIDTH*PSUM_WIDTH, array outputs; column c at bits [c*PSUM_WIDTH +: PSUM_WIDTH].
- `psum_valid`, input, 1, column 0 of `psum_in` carries a valid row this cycle.
- `row_data`, output, ARRAY_WIDTH*PSUM_WIDTH, aligned row at FIFO head, same column packing.
- `row_valid`, output, 1, FIFO non-empty.
- `row_ready`, input, 1, downstream accepts head row.
- `fifo_count`, output, $clog2(FIFO_DEPTH)+1, rows currently buffered.
- `overflow`, output, 1, sticky; a row was dropped.
- `rows_out`, output, 16, count of rows popped, wraps modulo 2^16.

## Operation

- Row k arrives with column 0 valid in cycle t (`psum_valid`=1). Column c of the same row is valid in cycle t+c. No per-column valid exists; `psum_valid` is the only qualifier.
- Deskew: column c passes through a register delay line of W-1-c stages. Column W-1 passes straight through. `psum_valid` passes through a W-1 stage delay line (`aligned_valid`). All deskew registers shift every cycle unconditionally.
- In cycle t+W-1, `aligned_valid`=1 and the delayed columns form the complete row.
- FIFO push occurs when `aligned_valid`=1. Pop occurs when `row_valid` && `row_ready`.
- Push with FIFO not full: row written at tail.
- Push with FIFO full and pop in the same cycle: both occur, and the count stays at FIFO_DEPTH.
- Push with FIFO full and no pop: row dropped, contents unchanged, `overflow` set to 1 the following cycle.
- `overflow` stays at 1 until reset.
- Pop from an empty FIFO is impossible, because `row_valid`=0.
- `rows_out` increments by 1 on each pop. It goes from 0xFFFF to 0x0000.
- Back-to-back rows (`psum_valid` held high) are supported at one row per cycle.
- Reset, asynchronous, including mid-operation:
  - deskew data and valid lines cleared;
  - FIFO pointers and count go to 0;
  - `row_valid`=0, `row_data`=0, `fifo_count`=0, `overflow`=0, `rows_out`=0;
  - in-flight rows are discarded, and no partial row is pushed after reset release.
- Storage is data-only, with no arithmetic. Widths pass through unchanged.

## Timing

- Latency: `psum_valid` in cycle t gives `row_valid`=1 in cycle t+W when the FIFO is empty. For W=4, that is 4 cycles.
- `row_data` is registered from FIFO head memory. It is valid whenever `row_valid`=1 and holds stable while `row_valid` && !`row_ready`.
- `fifo_count` and `row_valid` update on the clock edge following a push or pop.
- `overflow` asserts on the edge ending the dropping cycle.
- No combinational path from `row_ready` to any output.
- The array side has no ready signal. Input is never stalled.

## Test plan

- **Single row, W=4.**
  - Stimulus: `psum_valid`=1 at t0 and columns [90,100,110,120] delivered skewed: col0=90 at t0, col1=100 at t0+1, col2=110 at t0+2, col3=120 at t0+3. `row_ready`=1.
  - Required response: `row_valid`=1 at t0+4 with `row_data`={120,110,100,90} (col3..col0) for exactly one cycle, then `rows_out`=1.
- **Four back-to-back rows.**
  - Stimulus: skewed rows [90,100,110,120], [202,228,254,280], [314,356,398,440], [426,484,542,600]. `row_ready`=1.
  - Required response: four consecutive `row_valid` cycles starting at t0+4, in order and correctly aligned, then `rows_out`=4.
- **Back-pressure.**
  - Stimulus: `row_ready`=0 while the four rows above arrive.
  - Required response: `fifo_count` reaches 4 and `overflow` stays 0. Then `row_ready`=1 drains the rows in order, and `fifo_count` returns to 0.
- **Overflow.**
  - Stimulus: `row_ready`=0 and five rows arrive.
  - Required response: the 5th row is dropped, `overflow`=1 one cycle after its aligned cycle, and the FIFO holds rows 1–4 unchanged.
- **Full plus simultaneous pop.**
  - Stimulus: FIFO full, and `row_ready`=1 in the cycle the 5th row aligns.
  - Required response: no overflow, `fifo_count` stays 4, and the 5th row is delivered last.
- **Mid-operation reset.**
  - Stimulus: assert `rst_n`=0 two cycles after `psum_valid` with 2 rows buffered.
  - Required response: all outputs go to 0 immediately. After release with no new input, `row_valid` stays 0 for ≥8 cycles.
